// File: rtl/i2c_reg_slave.sv
// rtl/i2c_reg_slave.sv - register-bus responder with TX/RX byte FIFOs for the I2C core
// Optional interrupt logic is enabled by defining I2C_REG_IRQ_EN.
module i2c_reg_slave #(
    parameter int              WAIT_STATES  = 1,
    parameter int              FIFO_DEPTH   = 4,
    parameter logic [15:0]     PRESCALE_RST = 16'h00F9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [3:0]  reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        reg_ready,
    output logic        core_en,
    output logic        core_start,
    output logic        core_stop,
    output logic        core_rw,
    output logic        core_ack_en,
    output logic [15:0] prescale,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_pop,
    input  logic        rx_push,
    input  logic [7:0]  rx_data,
    input  logic        core_busy,
    input  logic        core_nack,
    input  logic        core_arb_lost,
    output logic        irq
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [2:0] WS_LAST  = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [2:0]  r_wait_cnt;
    logic [3:0]  r_addr;
    logic [7:0]  r_wdata;
    logic        r_is_wr;
    logic        r_is_rd;

    logic        r_ctrl_en;
    logic        r_ctrl_rw;
    logic        r_ctrl_ack;
    logic [15:0] r_prescale;
    logic        r_nack;
    logic        r_arb_lost;
    logic        r_tx_ovf;
    logic        r_rx_ovf;

    logic [7:0]  r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wp;
    logic [AW-1:0] r_tx_rp;
    logic [AW:0]   r_tx_cnt;
    logic [7:0]  r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rx_wp;
    logic [AW-1:0] r_rx_rp;
    logic [AW:0]   r_rx_cnt;

    logic        w_req;
    logic        w_fire;
    logic [3:0]  w_addr;
    logic [7:0]  w_wdata;
    logic        w_is_wr;
    logic        w_is_rd;
    logic        w_wr;
    logic        w_rd;
    logic        w_status_wr;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_tx_push;
    logic        w_tx_push_ok;
    logic        w_tx_pop_ok;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic        w_rx_push_ok;
    logic        w_rx_pop_ok;
    logic [7:0]  w_status;
    logic [7:0]  w_rdata_mux;

    assign w_req   = reg_wr | reg_rd;
    // With no wait states the access completes straight out of IDLE, so use the live bus inputs there.
    assign w_fire  = (r_state == S_IDLE && w_req && NO_WAIT) ||
                     (r_state == S_WAIT && r_wait_cnt == WS_LAST);
    assign w_addr  = (r_state == S_IDLE) ? reg_addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? reg_wdata : r_wdata;
    assign w_is_wr = (r_state == S_IDLE) ? reg_wr : r_is_wr;
    assign w_is_rd = (r_state == S_IDLE) ? (reg_rd & ~reg_wr) : r_is_rd;
    assign w_wr    = w_fire & w_is_wr;
    assign w_rd    = w_fire & w_is_rd;
    assign w_status_wr = w_wr && (w_addr == 4'h1);

    assign w_tx_full    = (r_tx_cnt == FULL_CNT);
    assign w_tx_empty   = (r_tx_cnt == '0);
    assign w_tx_push    = w_wr && (w_addr == 4'h4);
    assign w_tx_pop_ok  = tx_pop && !w_tx_empty;
    assign w_tx_push_ok = w_tx_push && (!w_tx_full || w_tx_pop_ok);

    assign w_rx_full    = (r_rx_cnt == FULL_CNT);
    assign w_rx_empty   = (r_rx_cnt == '0);
    assign w_rx_pop_ok  = w_rd && (w_addr == 4'h5) && !w_rx_empty;
    assign w_rx_push_ok = rx_push && (!w_rx_full || w_rx_pop_ok);

    assign w_status = {r_rx_ovf, r_tx_ovf, r_arb_lost, r_nack,
                       ~w_rx_empty, w_tx_empty, w_tx_full, core_busy};

    assign core_en     = r_ctrl_en;
    assign core_rw     = r_ctrl_rw;
    assign core_ack_en = r_ctrl_ack;
    assign prescale    = r_prescale;
    assign tx_data     = r_tx_mem[r_tx_rp];
    assign tx_valid    = !w_tx_empty;

`ifdef I2C_REG_IRQ_EN
    logic [3:0] r_irq_en;
    logic [3:0] w_irq_stat;
    logic       r_irq;

    assign w_irq_stat = {r_arb_lost, r_nack, w_tx_empty, ~w_rx_empty};
    assign irq        = r_irq;

    // Interrupt enables and the registered interrupt output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && w_addr == 4'h6)
                r_irq_en <= w_wdata[3:0];
            r_irq <= |(r_irq_en & w_irq_stat);
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read-data selection for the access being completed.
    always_comb begin
        w_rdata_mux = 8'h00;
        case (w_addr)
            4'h0: w_rdata_mux = {3'b000, r_ctrl_ack, r_ctrl_rw, 2'b00, r_ctrl_en};
            4'h1: w_rdata_mux = w_status;
            4'h2: w_rdata_mux = r_prescale[7:0];
            4'h3: w_rdata_mux = r_prescale[15:8];
            4'h5: w_rdata_mux = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
`ifdef I2C_REG_IRQ_EN
            4'h6: w_rdata_mux = {4'h0, r_irq_en};
            4'h7: w_rdata_mux = {4'h0, w_irq_stat};
`endif
            default: w_rdata_mux = 8'h00;
        endcase
    end

    // Access FSM with registered handshake, read data and start/stop pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_wr    <= 1'b0;
            r_is_rd    <= 1'b0;
            reg_ready  <= 1'b0;
            reg_rdata  <= 8'h00;
            core_start <= 1'b0;
            core_stop  <= 1'b0;
        end else begin
            reg_ready  <= 1'b0;
            core_start <= 1'b0;
            core_stop  <= 1'b0;
            if (w_fire) begin
                reg_ready <= 1'b1;
                if (w_rd)
                    reg_rdata <= w_rdata_mux;
                if (w_wr && w_addr == 4'h0) begin
                    core_start <= w_wdata[1];
                    core_stop  <= w_wdata[2];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr     <= reg_addr;
                        r_wdata    <= reg_wdata;
                        r_is_wr    <= reg_wr;
                        r_is_rd    <= reg_rd & ~reg_wr;
                        r_wait_cnt <= '0;
                        r_state    <= NO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == WS_LAST)
                        r_state <= S_RESP;
                    else
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Control, prescale and sticky status flags; a new event beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_en  <= 1'b0;
            r_ctrl_rw  <= 1'b0;
            r_ctrl_ack <= 1'b0;
            r_prescale <= PRESCALE_RST;
            r_nack     <= 1'b0;
            r_arb_lost <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_rx_ovf   <= 1'b0;
        end else begin
            if (w_wr && w_addr == 4'h0) begin
                r_ctrl_en  <= w_wdata[0];
                r_ctrl_rw  <= w_wdata[3];
                r_ctrl_ack <= w_wdata[4];
            end
            if (w_wr && w_addr == 4'h2)
                r_prescale[7:0] <= w_wdata;
            if (w_wr && w_addr == 4'h3)
                r_prescale[15:8] <= w_wdata;
            r_nack     <= core_nack | (r_nack & ~(w_status_wr & w_wdata[4]));
            r_arb_lost <= core_arb_lost | (r_arb_lost & ~(w_status_wr & w_wdata[5]));
            r_tx_ovf   <= (w_tx_push & ~w_tx_push_ok) | (r_tx_ovf & ~(w_status_wr & w_wdata[6]));
            r_rx_ovf   <= (rx_push & ~w_rx_push_ok) | (r_rx_ovf & ~(w_status_wr & w_wdata[7]));
        end
    end

    // FIFO pointers and occupancy counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push_ok) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop_ok)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_tx_push_ok && !w_tx_pop_ok)      r_tx_cnt <= r_tx_cnt + ONE_CNT;
            else if (!w_tx_push_ok && w_tx_pop_ok) r_tx_cnt <= r_tx_cnt - ONE_CNT;
            if (w_rx_push_ok) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop_ok)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_push_ok && !w_rx_pop_ok)      r_rx_cnt <= r_rx_cnt + ONE_CNT;
            else if (!w_rx_push_ok && w_rx_pop_ok) r_rx_cnt <= r_rx_cnt - ONE_CNT;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every use.
    always_ff @(posedge clk) begin
        if (w_tx_push_ok) r_tx_mem[r_tx_wp] <= w_wdata;
        if (w_rx_push_ok) r_rx_mem[r_rx_wp] <= rx_data;
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb/tb_i2c_reg_slave.sv - scoreboard bench for i2c_reg_slave
module tb_i2c_reg_slave;

    localparam int WS = 1;
`ifdef I2C_REG_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
    localparam logic [7:0] IRQ_EN_RB = 8'h04;
`else
    localparam logic IRQ_ON = 1'b0;
    localparam logic [7:0] IRQ_EN_RB = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [3:0]  reg_addr = 4'h0;
    logic [7:0]  reg_wdata = 8'h00;
    logic [7:0]  reg_rdata;
    logic        reg_ready;
    logic        core_en, core_start, core_stop, core_rw, core_ack_en;
    logic [15:0] prescale;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_pop = 1'b0;
    logic        rx_push = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        core_busy = 1'b0;
    logic        core_nack = 1'b0;
    logic        core_arb_lost = 1'b0;
    logic        irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_rdata = 8'h00;
    logic        resp_start;
    logic        resp_stop;

    i2c_reg_slave #(.WAIT_STATES(WS), .FIFO_DEPTH(4), .PRESCALE_RST(16'h00F9)) dut (
        .clk(clk), .rst(rst),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_ready(reg_ready),
        .core_en(core_en), .core_start(core_start), .core_stop(core_stop),
        .core_rw(core_rw), .core_ack_en(core_ack_en), .prescale(prescale),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_pop(tx_pop),
        .rx_push(rx_push), .rx_data(rx_data),
        .core_busy(core_busy), .core_nack(core_nack), .core_arb_lost(core_arb_lost),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access: expected read data goes into the scoreboard at issue, is popped on reg_ready.
    task automatic bus(input logic wr, input logic rd, input logic [3:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp, input string tag);
        int n;
        logic got;
        logic [7:0] e;
        if (rd && !wr) exp_q.push_back(exp);
        else if (rd && wr) exp_q.push_back(last_rdata);
        @(posedge clk); #1;
        reg_wr = wr; reg_rd = rd; reg_addr = addr; reg_wdata = wdata;
        n = 0; got = 1'b0;
        while (!got && n <= 20) begin
            @(negedge clk);
            if (reg_ready) got = 1'b1;
            else n++;
        end
        check({tag, "_lat"}, 16'(n), 16'(1 + WS));
        resp_start = core_start;
        resp_stop  = core_stop;
        if (rd) begin
            e = exp_q.pop_front();
            if (got) begin
                check(tag, {8'h00, reg_rdata}, {8'h00, e});
                if (!wr) last_rdata = e;
            end
        end
        reg_wr = 1'b0; reg_rd = 1'b0;
        @(negedge clk);
        check({tag, "_1cyc"}, 16'(reg_ready), 16'h0);
    endtask

    initial begin
        logic seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 16'(reg_ready), 16'h0);
        check("rst_rdata", {8'h00, reg_rdata}, 16'h0000);
        check("rst_en", 16'(core_en), 16'h0);
        check("rst_prescale", prescale, 16'h00F9);
        check("rst_txvalid", 16'(tx_valid), 16'h0);
        check("rst_irq", 16'(irq), 16'h0);

        bus(1'b0, 1'b1, 4'h2, 8'h00, 8'hF9, "rd_pre_lo");
        bus(1'b0, 1'b1, 4'h3, 8'h00, 8'h00, "rd_pre_hi");

        bus(1'b1, 1'b0, 4'h0, 8'h03, 8'h00, "wr_ctrl");
        check("start_pulse", 16'(resp_start), 16'h1);
        check("stop_pulse", 16'(resp_stop), 16'h0);
        check("start_gone", 16'(core_start), 16'h0);
        check("core_en", 16'(core_en), 16'h1);
        bus(1'b0, 1'b1, 4'h0, 8'h00, 8'h01, "rd_ctrl");
        bus(1'b0, 1'b1, 4'h9, 8'h00, 8'h00, "rd_unmapped");

        for (int i = 0; i < 5; i++)
            bus(1'b1, 1'b0, 4'h4, 8'hA1 + 8'(i), 8'h00, "wr_tx");
        check("tx_head", {8'h00, tx_data}, 16'h00A1);
        bus(1'b0, 1'b1, 4'h1, 8'h00, 8'h42, "st_txovf");
        bus(1'b1, 1'b0, 4'h1, 8'h40, 8'h00, "w1c_txovf");
        bus(1'b0, 1'b1, 4'h1, 8'h00, 8'h02, "st_txfull");
        bus(1'b0, 1'b1, 4'h4, 8'h00, 8'h00, "rd_txdata");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tx_seq", {8'h00, tx_data}, {8'h00, 8'hA1 + 8'(i)});
            tx_pop = 1'b1;
            @(negedge clk);
            tx_pop = 1'b0;
        end
        check("tx_drained", 16'(tx_valid), 16'h0);
        bus(1'b0, 1'b1, 4'h1, 8'h00, 8'h04, "st_txempty");

        @(negedge clk); rx_push = 1'b1; rx_data = 8'h5C;
        @(negedge clk); rx_data = 8'h3E;
        @(negedge clk); rx_push = 1'b0;
        bus(1'b0, 1'b1, 4'h1, 8'h00, 8'h0C, "st_rx2");
        bus(1'b0, 1'b1, 4'h5, 8'h00, 8'h5C, "rx_pop1");
        bus(1'b0, 1'b1, 4'h1, 8'h00, 8'h0C, "st_rx1");
        bus(1'b0, 1'b1, 4'h5, 8'h00, 8'h3E, "rx_pop2");
        bus(1'b0, 1'b1, 4'h1, 8'h00, 8'h04, "st_rx0");
        bus(1'b0, 1'b1, 4'h5, 8'h00, 8'h00, "rx_empty");

        bus(1'b1, 1'b0, 4'h6, 8'h04, 8'h00, "wr_irqen");
        bus(1'b0, 1'b1, 4'h6, 8'h00, IRQ_EN_RB, "rd_irqen");
        @(posedge clk); #1 core_nack = 1'b1;
        @(posedge clk); #1 core_nack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("irq_nack", 16'(irq), 16'(IRQ_ON));
        bus(1'b0, 1'b1, 4'h1, 8'h00, 8'h14, "st_nack");
        bus(1'b1, 1'b0, 4'h1, 8'h10, 8'h00, "w1c_nack");
        check("irq_clr", 16'(irq), 16'h0);
        bus(1'b0, 1'b1, 4'h1, 8'h00, 8'h04, "st_nackclr");

        core_busy = 1'b1;
        bus(1'b0, 1'b1, 4'h1, 8'h00, 8'h05, "st_busy");
        core_busy = 1'b0;

        bus(1'b1, 1'b1, 4'h2, 8'h37, 8'h00, "wr_rd_both");
        check("pre_written", prescale, 16'h0037);
        bus(1'b0, 1'b1, 4'h2, 8'h00, 8'h37, "rd_pre_new");

        @(posedge clk); #1;
        reg_wr = 1'b1; reg_addr = 4'h4; reg_wdata = 8'h77;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (reg_ready) seen = 1'b1;
        end
        reg_wr = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        last_rdata = 8'h00;
        repeat (3) begin
            @(negedge clk);
            if (reg_ready) seen = 1'b1;
        end
        check("abort_noready", 16'(seen), 16'h0);
        check("abort_txempty", 16'(tx_valid), 16'h0);
        check("abort_rdata", {8'h00, reg_rdata}, 16'h0000);
        bus(1'b0, 1'b1, 4'h1, 8'h00, 8'h04, "st_after_rst");
        bus(1'b0, 1'b1, 4'h2, 8'h00, 8'hF9, "pre_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
- Register-bus responder (slave end) for the I2C controller.
- Decodes reg_wr/reg_rd accesses with a ready handshake and exposes CTRL, STATUS, PRESCALE and FIFO-backed TX/RX data registers to the I2C core.
- Buffers TX and RX bytes in small FIFOs.
- Sits between the bus master and the I2C bit/byte engine.

Parameters:
- WAIT_STATES, 1, extra cycles between request capture and reg_ready (0..7)
- FIFO_DEPTH, 4, entries in each of TX and RX FIFO (power of 2, >=2)
- PRESCALE_RST, 16'h00F9, reset value of the prescale register

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- reg_wr  in  1  write request, held until reg_ready
- reg_rd  in  1  read request, held until reg_ready
- reg_addr  in  4  register address
- reg_wdata  in  8  write data
- reg_rdata  out  8  read data, valid when reg_ready=1
- reg_ready  out  1  one-cycle access completion
- core_en  out  1  CTRL[0]
- core_start  out  1  one-cycle start pulse
- core_stop  out  1  one-cycle stop pulse
- core_rw  out  1  CTRL[3], 1=read transfer
- core_ack_en  out  1  CTRL[4], master ACK on received bytes
- prescale  out  16  SCL divider
- tx_data  out  8  TX FIFO head
- tx_valid  out  1  TX FIFO non-empty
- tx_pop  in  1  core consumes TX head
- rx_push  in  1  core delivers received byte
- rx_data  in  8  received byte
- core_busy  in  1  transfer in progress
- core_nack  in  1  pulse, NACK detected
- core_arb_lost  in  1  pulse, arbitration lost
- irq  out  1  interrupt (see Optional Feature)

Behaviour:
- Interface decided: one clock `clk`; reset `rst` asynchronous, active-high.
- Reset values:
  - reg_ready=0, reg_rdata=8'h00
  - CTRL=0, prescale=PRESCALE_RST
  - FIFOs empty, sticky flags 0, irq=0
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if reg_wr|reg_rd, capture addr/wdata/type. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: counts WAIT_STATES cycles, then RESP.
  - RESP: reg_ready=1 for exactly one cycle, then IDLE.
  - Latency: request seen in cycle t gives reg_ready in cycle t+1+WAIT_STATES.
- reg_wr and reg_rd both high: write performed, read ignored; reg_rdata unchanged.
- Side effects and reg_rdata update happen on the clock edge entering RESP. reg_rdata holds its value until the next read.
- Register map:
  - 0x0 CTRL: [0]en, [1]start, [2]stop, [3]rw, [4]ack_en.
    - Writing start=1 or stop=1 produces a one-cycle core_start/core_stop pulse in the RESP cycle.
    - Bits 1 and 2 read as 0.
  - 0x1 STATUS (RO except W1C bits): [0]core_busy, [1]tx_full, [2]tx_empty, [3]rx_valid, [4]nack (sticky, W1C), [5]arb_lost (sticky, W1C), [6]tx_ovf (sticky, W1C), [7]rx_ovf (sticky, W1C).
  - 0x2 PRESCALE_LO, 0x3 PRESCALE_HI: R/W.
  - 0x4 TXDATA: write pushes; read returns 0x00.
  - 0x5 RXDATA: read pops head; write ignored.
  - 0x6 IRQ_EN, 0x7 IRQ_STAT: see Optional Feature.
  - 0x8-0xF: read 0x00, write ignored.
- TX FIFO:
  - Push when full: byte dropped, tx_ovf set.
  - tx_pop when empty: ignored.
  - Push and pop in the same cycle are both honoured; occupancy unchanged.
- RX FIFO:
  - rx_push when full: byte dropped, rx_ovf set.
  - RXDATA read when empty returns 8'h00, no pop.
  - Same-cycle push and pop both honoured.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Sticky flag set and W1C clear in the same cycle: set wins.
- rst asserted mid-access: FSM returns to IDLE immediately, and no reg_ready is issued for the aborted access.

Optional Feature:
- Macro: I2C_REG_IRQ_EN.
- Defined:
  - IRQ_EN (0x6) bits [0]rx_valid, [1]tx_empty, [2]nack, [3]arb_lost.
  - IRQ_STAT (0x7) reads the raw sources for those bits, with nack and arb_lost W1C via STATUS.
  - irq = |(IRQ_EN & IRQ_STAT), registered, one cycle latency.
- Not defined: 0x6/0x7 read 0x00, writes ignored, irq tied to 0.

Test Plan:
- Reset, then read 0x2/0x3 with WAIT_STATES=1 -> reg_rdata 8'hF9 then 8'h00; reg_ready exactly 2 cycles after reg_rd rises.
- Write 0x0=8'h03 -> core_en=1, single-cycle core_start in the RESP cycle; a later read of 0x0 returns 8'h01.
- Push 5 bytes 0xA1..0xA5 to 0x4 with no tx_pop -> tx_data=0xA1, STATUS[1]=1, STATUS[6]=1; write 0x1=8'h40 clears tx_ovf.
- rx_push 0x5C, 0x3E, then read 0x5 three times -> 0x5C, 0x3E, 0x00; STATUS[3] drops after the second read.
- Pulse core_nack with IRQ_EN=8'h04 (macro defined) -> irq=1 next cycle; W1C STATUS[4] -> irq=0; with macro undefined irq stays 0.
- Assert rst during WAIT of a TXDATA write -> no reg_ready, TX FIFO empty; simultaneous reg_wr+reg_rd to 0x2 writes wdata and leaves reg_rdata unchanged.
